// File: rtl/keypad_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// keypad_scanner -- matrix keypad scanner with press/release debounce, key
// encoding and ghost lockout; auto-repeat when KEYPAD_REPEAT_EN is defined.
// Revision: 1.0
// ============================================================================
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic                                  clk,
  input  logic                                  nRst,
  input  logic [NUM_ROWS-1:0]                   read_row,
  output logic [NUM_COLS-1:0]                   scan_col,
  output logic [NUM_ROWS+NUM_COLS-1:0]          cur_key,
  output logic [$clog2(NUM_ROWS*NUM_COLS)-1:0]  key_code,
  output logic                                  strobe,
  output logic                                  release_o,
  output logic                                  held,
  output logic                                  multi_err
);
  localparam int c_KEY_W = $clog2(NUM_ROWS*NUM_COLS);
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_COLS-1:0] c_COL_FIRST = {1'b1, {(NUM_COLS-1){1'b0}}};

  typedef enum logic [2:0] {
    SCAN      = 3'd0,
    DEB_PRESS = 3'd1,
    PRESSED   = 3'd2,
    DEB_REL   = 3'd3,
    LOCKOUT   = 3'd4
  } state_t;

  state_t                         r_state, w_state;
  logic [NUM_COLS-1:0]            r_col, w_col;
  logic [NUM_ROWS-1:0]            r_snap, w_snap;
  logic [c_CNT_W-1:0]             r_cnt, w_cnt;
  logic [NUM_ROWS+NUM_COLS-1:0]   r_cur_key, w_cur_key;
  logic [c_KEY_W-1:0]             r_key_code, w_key_code;
  logic                           r_strobe, w_strobe;
  logic                           r_release, w_release;
  logic                           r_held, w_held;
  logic                           r_multi, w_multi;

  logic [NUM_COLS-1:0]            w_col_rot;
  logic                           w_cnt_done;
  logic                           w_snap_multi;
  logic [c_KEY_W-1:0]             w_code;
  int                             w_row_idx;
  int                             w_col_idx;

  assign w_col_rot    = {r_col[0], r_col[NUM_COLS-1:1]};
  assign w_cnt_done   = (r_cnt == c_CNT_LAST);
  assign w_snap_multi = |(r_snap & (r_snap - 1'b1));

  // Indices count from the MSB, so bit i maps to position WIDTH-1-i.
  always_comb begin
    w_row_idx = 0;
    w_col_idx = 0;
    for (int i = 0; i < NUM_ROWS; i++) if (r_snap[i]) w_row_idx = NUM_ROWS - 1 - i;
    for (int j = 0; j < NUM_COLS; j++) if (r_col[j])  w_col_idx = NUM_COLS - 1 - j;
    w_code = c_KEY_W'(w_row_idx * NUM_COLS + w_col_idx);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_REP_W   = (c_REP_MAX > 1) ? $clog2(c_REP_MAX) : 1;
  localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

  logic [c_REP_W-1:0] r_rep_cnt, w_rep_cnt;
  logic               r_rep_run, w_rep_run;

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_rep_cnt <= '0;
      r_rep_run <= 1'b0;
    end else begin
      r_rep_cnt <= w_rep_cnt;
      r_rep_run <= w_rep_run;
    end
  end
`endif

  always_comb begin
    w_state    = r_state;
    w_col      = r_col;
    w_snap     = r_snap;
    w_cnt      = r_cnt;
    w_cur_key  = r_cur_key;
    w_key_code = r_key_code;
    w_held     = r_held;
    w_strobe   = 1'b0;
    w_release  = 1'b0;
    w_multi    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    // Repeat timing only survives while PRESSED stays stable.
    w_rep_cnt  = '0;
    w_rep_run  = 1'b0;
`endif
    case (r_state)
      SCAN: begin
        if (r_col == '0) begin
          w_col = c_COL_FIRST;
        end else if (read_row != '0) begin
          w_state = DEB_PRESS;
          w_snap  = read_row;
          w_cnt   = '0;
        end else begin
          w_col = w_col_rot;
        end
      end
      DEB_PRESS: begin
        if (read_row != r_snap) begin
          w_state = SCAN;
          w_col   = w_col_rot;
        end else if (w_cnt_done) begin
          if (w_snap_multi) begin
            w_state = LOCKOUT;
            w_multi = 1'b1;
            w_cnt   = '0;
          end else begin
            w_state    = PRESSED;
            w_cur_key  = {r_snap, r_col};
            w_key_code = w_code;
            w_held     = 1'b1;
            w_strobe   = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (read_row != r_snap) begin
          w_state = DEB_REL;
          w_cnt   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          w_rep_run = r_rep_run;
          if (r_rep_cnt == (r_rep_run ? c_PERIOD_LAST : c_DELAY_LAST)) begin
            w_strobe  = 1'b1;
            w_rep_run = 1'b1;
          end else begin
            w_rep_cnt = r_rep_cnt + 1'b1;
          end
        end
`endif
      end
      DEB_REL: begin
        if (read_row == '0) begin
          if (w_cnt_done) begin
            w_state    = SCAN;
            w_col      = w_col_rot;
            w_cur_key  = '0;
            w_key_code = '0;
            w_held     = 1'b0;
            w_release  = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else if (read_row == r_snap) begin
          w_state = PRESSED;
        end else begin
          w_cnt = '0;
        end
      end
      LOCKOUT: begin
        if (read_row == '0) begin
          if (w_cnt_done) begin
            w_state = SCAN;
            w_col   = w_col_rot;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt = '0;
        end
      end
      default: w_state = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      r_state    <= SCAN;
      r_col      <= '0;
      r_snap     <= '0;
      r_cnt      <= '0;
      r_cur_key  <= '0;
      r_key_code <= '0;
      r_strobe   <= 1'b0;
      r_release  <= 1'b0;
      r_held     <= 1'b0;
      r_multi    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_col      <= w_col;
      r_snap     <= w_snap;
      r_cnt      <= w_cnt;
      r_cur_key  <= w_cur_key;
      r_key_code <= w_key_code;
      r_strobe   <= w_strobe;
      r_release  <= w_release;
      r_held     <= w_held;
      r_multi    <= w_multi;
    end
  end

  assign scan_col  = r_col;
  assign cur_key   = r_cur_key;
  assign key_code  = r_key_code;
  assign strobe    = r_strobe;
  assign release_o = r_release;
  assign held      = r_held;
  assign multi_err = r_multi;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised keypad matrix scanner with debounce, press/release events, encoded key index and ghost (multi-key) detection.
- Drives a one-hot column strobe, samples active-high row inputs and holds the active column while a key is down.
- Feeds the input-decode logic with a one-cycle strobe per debounced press.
- Next-generation keypad front end: generalised in matrix size, with press/release debounce and optional auto-repeat.

Parameters:
- NUM_ROWS, 4, row input width (>=2)
- NUM_COLS, 4, column output width (>=2)
- DEBOUNCE_CYCLES, 2, consecutive stable samples required for press and for release (>=1)
- REPEAT_DELAY, 50, cycles held before the first auto-repeat (repeat build only)
- REPEAT_PERIOD, 10, cycles between auto-repeats (repeat build only)

Ports:
- clk  in  1  system clock
- nRst  in  1  reset, synchronous active-low
- read_row  in  NUM_ROWS  row sense, active high, MSB = row index 0
- scan_col  out  NUM_COLS  one-hot column drive, MSB = column index 0
- cur_key  out  NUM_ROWS+NUM_COLS  {row one-hot, col one-hot} of the held key, 0 when none
- key_code  out  $clog2(NUM_ROWS*NUM_COLS)  row_idx*NUM_COLS+col_idx of the held key
- strobe  out  1  one-cycle pulse per debounced press (and per repeat)
- release_o  out  1  one-cycle pulse on debounced release
- held  out  1  high while a debounced key is held
- multi_err  out  1  one-cycle pulse when >1 row bit is seen in the debounced snapshot

Behaviour:
- Clock and reset: single clock domain. "One clock; reset is synchronous and active-low."
- Reset values (nRst low at a posedge): scan_col=0, cur_key=0, key_code=0, strobe=0, release_o=0, held=0, multi_err=0, state=SCAN, column pointer=0.
- All outputs are registered.
- States: SCAN, DEB_PRESS, PRESSED, DEB_REL, LOCKOUT.
- SCAN, startup:
  - First posedge with nRst high: scan_col = 1 at MSB (column 0).
- SCAN, rotation:
  - Each posedge with read_row==0: scan_col rotates right.
  - Wraps from the LSB back to the MSB.
- SCAN, detection:
  - read_row!=0 and scan_col!=0 at posedge E: enter DEB_PRESS.
  - Snapshot read_row and freeze scan_col; counter=0.
- DEB_PRESS:
  - read_row must equal the snapshot at edges E+1..E+DEBOUNCE_CYCLES.
  - Any mismatch: return to SCAN, rotating to the next column on that edge, with no outputs.
  - Success at edge E+DEBOUNCE_CYCLES with a single-bit snapshot: PRESSED; cur_key, key_code and held load; strobe=1 for exactly one cycle.
  - Success with a multi-bit snapshot: LOCKOUT; multi_err pulses once; no strobe; cur_key stays 0.
- PRESSED:
  - Hold scan_col and cur_key while read_row==snapshot.
  - First edge R where read_row!=snapshot (zero or a different pattern): enter DEB_REL.
- DEB_REL:
  - Requires read_row==0 at edges R+1..R+DEBOUNCE_CYCLES.
  - read_row==snapshot during the window: back to PRESSED with no new strobe (bounce).
  - Any other nonzero value: restart the window.
  - Completion at edge R+DEBOUNCE_CYCLES: cur_key=0, key_code=0, held=0, release_o pulses one cycle; SCAN resumes at the next column on that edge.
- LOCKOUT:
  - Waits for DEBOUNCE_CYCLES consecutive read_row==0 samples, then returns to SCAN at the next column.
  - No release_o is pulsed.
- Row/col encoding: row_idx and col_idx are the position of the set bit counted from the MSB. key_code is computed combinationally and registered with cur_key.
- Reset mid-operation: the synchronous reset overrides every state and counter on the same edge; no pulse is emitted.
- strobe and release_o are never high in the same cycle.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a hold counter starts at the press strobe.
  - After REPEAT_DELAY cycles, strobe pulses again, then every REPEAT_PERIOD cycles while held.
  - The counter clears on leaving PRESSED; a bounce back from DEB_REL restarts it.
- Not defined: exactly one strobe per press, and no repeat counters are synthesised.

Test Plan:
- Reset: nRst=0 with read_row=4'b1000 for 2 cycles -> all outputs 0; first edge after release -> scan_col=4'b1000, strobe=0.
- Rotation: read_row=0 -> scan_col sequence 1000, 0100, 0010, 0001, 1000 on consecutive edges; cur_key=0 throughout.
- Press: read_row=4'b0010 held while scan_col=4'b1000 -> strobe=1 exactly 2 edges after detection; cur_key=8'b0010_1000, key_code=8, held=1; strobe=0 on the following cycle; scan_col stays 1000 for 10 further cycles.
- Bounce: read_row=4'b0100 at column 0001 for 1 cycle, then 0 -> no strobe; scan_col continues to 1000. Then press, drop to 0 for 1 cycle, re-assert 0100 -> no second strobe, no release_o. Final release -> release_o one pulse 2 edges after first zero, cur_key=0.
- Ghost: read_row=4'b0110 held -> multi_err one pulse; strobe stays 0; scanning resumes 2 zero samples after release.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=5, REPEAT_PERIOD=3: hold a key 15 cycles -> strobe at press, +5, +8, +11, +14; with the macro undefined -> a single strobe.
